// File: rtl/nios_msg_pkg.sv
// Shared constants and types for the Nios PIO mailbox to network bridge.
package nios_msg_pkg;

  // Bit positions inside the 8-bit PIO address ports
  localparam int SEND_TGL = 7;
  localparam int ACK_TGL  = 6;
  localparam int RECV_TGL = 7;
  localparam int TX_BUSY  = 6;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } rx_state_t;

  // One network message: node address (dest on tx, src on rx) plus payload
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } msg_t;

endpackage

// File: rtl/msg_fifo.sv
// Small synchronous FIFO with power-of-two depth; push and pop may coincide.
module msg_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 38
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is only legal when a pop frees the slot this cycle
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage, pointers (wrap naturally on power-of-two depth) and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/nios_msg_bridge.sv
// Far end of the Nios PIO mailbox: turns send toggles into network tx
// transfers and presents buffered rx words to the Nios via a recv toggle.
module nios_msg_bridge
  import nios_msg_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W+1:0] send_addr,
  input  logic [DATA_W-1:0] send_data,
  output logic [ADDR_W+1:0] recv_addr,
  output logic [DATA_W-1:0] recv_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] tx_dest,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] rx_src,
  input  logic [DATA_W-1:0] rx_data,
  output logic              tx_overrun
);

  localparam int CW = $clog2(RX_DEPTH) + 1;

  logic                     armed;
  logic                     prev_s7, prev_a6;
  logic                     send_evt, ack_evt, slot_free;
  rx_state_t                state;
  logic                     recv_tgl;
  logic [ADDR_W-1:0]        recv_src;
  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic [ADDR_W+DATA_W-1:0] fifo_head;

  // armed stays low for the first edge after reset so the prev registers can
  // pick up whatever toggle state the (possibly un-reset) Nios is holding
  assign send_evt  = armed && (send_addr[SEND_TGL] ^ prev_s7);
  assign ack_evt   = armed && (send_addr[ACK_TGL] ^ prev_a6);
  assign slot_free = !tx_valid || tx_ready;

  // rx_ready looks at occupancy before any pop, so a full+pop cycle stays low
  assign rx_ready  = !fifo_full;
  assign fifo_push = rx_valid && !fifo_full;
  assign fifo_pop  = armed && !fifo_empty && ((state == IDLE) || ack_evt);

  assign recv_addr = {recv_tgl, tx_valid, recv_src};

  // Toggle edge detection with a one-cycle resync after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed   <= 1'b0;
      prev_s7 <= 1'b0;
      prev_a6 <= 1'b0;
    end else begin
      armed   <= 1'b1;
      prev_s7 <= send_addr[SEND_TGL];
      prev_a6 <= send_addr[ACK_TGL];
    end
  end

  // Single-entry tx holding register; a send into a busy slot is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_valid   <= 1'b0;
      tx_dest    <= '0;
      tx_data    <= '0;
      tx_overrun <= 1'b0;
    end else begin
      if (send_evt && slot_free) begin
        tx_valid <= 1'b1;
        tx_dest  <= send_addr[ADDR_W-1:0];
        tx_data  <= send_data;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (send_evt && !slot_free) tx_overrun <= 1'b1;
    end
  end

  // Rx presentation FSM: load head, pop and flip the recv toggle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      recv_tgl  <= 1'b0;
      recv_src  <= '0;
      recv_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            {recv_src, recv_data} <= fifo_head;
            recv_tgl              <= ~recv_tgl;
            state                 <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack_evt) begin
            if (fifo_pop) begin
              {recv_src, recv_data} <= fifo_head;
              recv_tgl              <= ~recv_tgl;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  msg_fifo #(
    .DEPTH (RX_DEPTH),
    .W     (ADDR_W + DATA_W)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({rx_src, rx_data}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Occupancy and full flag must always agree
  a_full_count: assert property (@(posedge clk) disable iff (reset)
    fifo_full == (fifo_count == CW'(RX_DEPTH)));

endmodule
